// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic decoder source stages.
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun,
        StFin
    } sc_state_e;

    localparam logic [7:0] ScDefTaps = 8'hB8;
    localparam logic [7:0] ScDefSeed = 8'h01;

    // Maximal-length Galois right-shift masks; 0 means no known mask for that width.
    function automatic logic [15:0] sc_max_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0E08;
            13:      taps = 16'h1C80;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hB400;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Galois right-shift LFSR with synchronous seed load; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned          LFSR_S  = 8,
    parameter logic [LFSR_S-1:0]    TAPS    = LFSR_S'(ScDefTaps),
    parameter logic [LFSR_S-1:0]    RST_VAL = LFSR_S'(ScDefSeed)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD,
    input  logic              EN,
    input  logic [LFSR_S-1:0] SEED,
    output logic [LFSR_S-1:0] Q
);

    logic [LFSR_S-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (LOAD) begin
            lfsr_d = (SEED == '0) ? LFSR_S'(1) : SEED;
        end else if (EN) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/sc_channel_src.sv
// Channel source: turns a latched probability into a stochastic bit-stream and
// sequences one INIT/RUN/DONE decoding frame.
module sc_channel_src
    import sc_pkg::*;
#(
    parameter int unsigned       LFSR_S   = 8,
    parameter logic [LFSR_S-1:0] TAPS     = LFSR_S'(ScDefTaps),
    parameter logic [LFSR_S-1:0] SEED     = LFSR_S'(ScDefSeed),
    parameter int unsigned       INIT_CYC = 8,
    parameter int unsigned       RUN_CYC  = 1024,
    parameter int unsigned       CNT_W    = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [LFSR_S-1:0] P,
    output logic              C,
    output logic              INIT,
    output logic [LFSR_S-1:0] SEL,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  CYC_CNT
);

    localparam logic [LFSR_S-1:0] SafeSeed = (SEED == '0) ? LFSR_S'(1) : SEED;
    localparam logic [CNT_W-1:0]  InitLast = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0]  RunLast  = CNT_W'(RUN_CYC - 1);

    sc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LFSR_S-1:0] p_q, p_d;
    logic [LFSR_S-1:0] lfsr_q;
    logic              lfsr_load, lfsr_en;

    sc_lfsr #(
        .LFSR_S  (LFSR_S),
        .TAPS    (TAPS),
        .RST_VAL (SafeSeed)
    ) u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (lfsr_load),
        .EN    (lfsr_en),
        .SEED  (SafeSeed),
        .Q     (lfsr_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d   = StInit;
                    cnt_d     = '0;
                    p_d       = P;
                    lfsr_load = 1'b1;
                end
            end
            StInit: begin
                lfsr_en = 1'b1;
                if (cnt_q == InitLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                lfsr_en = 1'b1;
                if (cnt_q == RunLast) begin
                    state_d = StFin;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Pure decode of registered state so reset drops every output without a clock.
    assign INIT    = (state_q == StInit);
    assign BUSY    = (state_q == StInit) || (state_q == StRun);
    assign DONE    = (state_q == StFin);
    assign C       = BUSY && (lfsr_q <= p_q);
    assign SEL     = lfsr_q;
    assign CYC_CNT = cnt_q;

endmodule

// File: tb/tb_sc_channel_src.sv
// Directed bench for sc_channel_src: a short-frame instance for timing and a
// full-period instance for probability exactness.
module tb_sc_channel_src;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  p_a, p_b;
    logic        c_a, init_a, busy_a, done_a;
    logic        c_b, init_b, busy_b, done_b;
    logic [7:0]  sel_a, sel_b;
    logic [10:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sc_channel_src #(.INIT_CYC(8), .RUN_CYC(16)) dut_a (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start_a),
        .P       (p_a),
        .C       (c_a),
        .INIT    (init_a),
        .SEL     (sel_a),
        .BUSY    (busy_a),
        .DONE    (done_a),
        .CYC_CNT (cnt_a)
    );

    sc_channel_src #(.INIT_CYC(8), .RUN_CYC(255)) dut_b (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start_b),
        .P       (p_b),
        .C       (c_b),
        .INIT    (init_b),
        .SEL     (sel_b),
        .BUSY    (busy_b),
        .DONE    (done_b),
        .CYC_CNT (cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] galois(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // One full frame on dut_b; optionally pokes START and P mid-RUN.
    task automatic frame_b(input logic [7:0] pval, input bit disturb, output int ones);
        ones    = 0;
        p_b     = pval;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("b_init", {init_b, busy_b, done_b, cnt_b}, {3'b110, 11'(i)});
            step();
        end
        for (int j = 0; j < 255; j++) begin
            if (j == 0 || j == 254) begin
                check("b_run", {init_b, busy_b, done_b, cnt_b}, {3'b010, 11'(j)});
            end
            if (j == 247) check("b_sel_period", sel_b, 8'h01);
            if (disturb && j == 10) begin
                p_b     = 8'hC0;
                start_b = 1'b1;
            end
            if (disturb && j == 11) start_b = 1'b0;
            ones += int'(c_b);
            step();
        end
        check("b_fin", {init_b, busy_b, done_b, c_b, cnt_b}, {4'b0010, 11'd0});
        step();
        check("b_idle", {init_b, busy_b, done_b, cnt_b}, 14'd0);
    endtask

    initial begin
        logic [7:0] seq [6];
        logic [7:0] m;
        int         ones;

        seq     = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        p_a     = 8'h00;
        p_b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            check("a_idle", {c_a, init_a, busy_a, done_a, cnt_a, sel_a}, {4'b0, 11'd0, 8'h01});
            check("b_idle_rst", {c_b, init_b, busy_b, done_b, cnt_b, sel_b}, {4'b0, 11'd0, 8'h01});
            step();
        end

        // Short frame: LFSR sequence and INIT/RUN/DONE timing.
        m       = 8'h01;
        p_a     = 8'hFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("a_init", {init_a, busy_a, done_a, cnt_a}, {3'b110, 11'(i)});
            if (i < 6) check("a_sel_seq", sel_a, seq[i]);
            else       check("a_sel", sel_a, m);
            m = galois(m);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            check("a_run", {init_a, busy_a, done_a, c_a, cnt_a}, {4'b0101, 11'(i)});
            check("a_sel_run", sel_a, m);
            m = galois(m);
            step();
        end
        check("a_fin", {init_a, busy_a, done_a, c_a, cnt_a}, {4'b0010, 11'd0});
        step();
        check("a_after", {init_a, busy_a, done_a, cnt_a}, 14'd0);
        step();
        check("a_after2", {init_a, busy_a, done_a}, 3'b000);

        // START held high: one IDLE cycle between frames.
        start_a = 1'b1;
        step();
        repeat (24) step();
        check("a_hold_fin", {busy_a, done_a}, 2'b01);
        step();
        check("a_hold_idle", {init_a, busy_a, done_a}, 3'b000);
        step();
        check("a_hold_restart", {init_a, busy_a, cnt_a, sel_a}, {2'b11, 11'd0, 8'h01});
        start_a = 1'b0;
        repeat (30) step();
        check("a_quiet", {busy_a, done_a}, 2'b00);

        // Probability extremes and exactness over a full period.
        frame_b(8'h00, 1'b0, ones);
        check("p00_ones", ones, 0);
        frame_b(8'hFF, 1'b0, ones);
        check("pff_ones", ones, 255);
        frame_b(8'h80, 1'b0, ones);
        check("p80_ones", ones, 128);
        frame_b(8'h40, 1'b1, ones);
        check("p40_disturbed_ones", ones, 64);
        for (int i = 0; i < 10; i++) begin
            check("b_no_second_frame", {init_b, busy_b, done_b}, 3'b000);
            step();
        end

        // Mid-frame reset at RUN cycle 5.
        p_b     = 8'hFF;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (13) step();
        check("b_pre_rst", {busy_b, c_b, cnt_b}, {2'b11, 11'd5});
        rst_n = 1'b0;
        #1;
        check("b_rst_async", {init_b, busy_b, c_b, done_b}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_rst_hold", {init_b, busy_b, c_b, done_b}, 4'b0000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_post_rst", {init_b, busy_b, done_b, c_b, cnt_b, sel_b},
                  {4'b0000, 11'd0, 8'h01});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sc_channel_src.md
Name: sc_channel_src

Overview:
- Upstream source stage for the stochastic equality-node array.
- Converts a latched channel probability P into a stochastic bit-stream C using an LFSR comparator.
- Exports the LFSR state as SEL, the edge-memory address source.
- Sequences one decoding frame: an INIT phase that preloads the node edge memories, then a fixed number of RUN (decoding) cycles, then a DONE pulse.

Parameters:
- LFSR_S, 8, LFSR and probability width in bits.
- TAPS, 8'hB8, Galois right-shift feedback mask; the default gives a maximal period of 255 for LFSR_S=8.
- SEED, 8'h01, LFSR value loaded on START; a value of 0 is forced to 1.
- INIT_CYC, 8, number of cycles INIT is held high; matches the edge-memory depth.
- RUN_CYC, 1024, number of decoding cycles per frame; must be ≥1.
- CNT_W, 11, cycle-counter width; must satisfy 2^CNT_W > max(INIT_CYC, RUN_CYC).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle frame request; sampled only in IDLE.
- P  in  LFSR_S  channel probability, scaled so that P/(2^LFSR_S−1) = Pr(C=1); latched on an accepted START.
- C  out  1  stochastic channel bit, feeds the c input of each node.
- INIT  out  1  edge-memory preload enable, feeds the INIT input of each node.
- SEL  out  LFSR_S  current LFSR state, the edge-memory address source.
- BUSY  out  1  high in the INIT and RUN states.
- DONE  out  1  one-cycle pulse when a frame completes.
- CYC_CNT  out  CNT_W  cycle index within the current phase.

Behaviour:
- States are IDLE, INIT, RUN, FIN. Reset (RST_N=0, asynchronous) sets:
  - state=IDLE, lfsr=SEED (0 forced to 1), p_reg=0, cnt=0;
  - all outputs 0, except SEL, which equals lfsr.
- IDLE:
  - START=1 → next cycle enters INIT with p_reg←P, lfsr←SEED, cnt←0.
  - START=0 → stay in IDLE; lfsr frozen.
- INIT:
  - INIT=1, BUSY=1.
  - Each cycle: lfsr advances and cnt increments.
  - When cnt==INIT_CYC−1 → next cycle enters RUN with cnt←0.
  - INIT is therefore high for exactly INIT_CYC cycles.
- RUN:
  - INIT=0, BUSY=1.
  - lfsr advances and cnt increments each cycle.
  - When cnt==RUN_CYC−1 → next cycle enters FIN.
- FIN:
  - DONE=1 for exactly one cycle; BUSY=0, C=0.
  - Next cycle enters IDLE with cnt←0.
- LFSR advance rule (Galois): lfsr_next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - lfsr is never 0.
  - With the default TAPS, the period is 255.
- Output decode, all combinational from registered state with zero added latency:
  - C = BUSY & (lfsr <= p_reg).
  - P=0 → C is constantly 0.
  - P=2^LFSR_S−1 → C is constantly 1 while BUSY.
  - Over one full LFSR period, the count of ones on C equals P exactly.
- SEL = lfsr at all times, including in IDLE.
- CYC_CNT = cnt. It is 0 in IDLE and FIN.
- START behaviour:
  - START while BUSY or in FIN is ignored; there is no queuing.
  - START held high continuously → a new frame begins the cycle after FIN returns to IDLE (the IDLE state lasts one cycle).
- P changing during a frame has no effect, because p_reg is latched only on START.
- Reset asserted mid-frame:
  - immediate return to IDLE;
  - INIT, BUSY and C drop asynchronously;
  - no DONE pulse is issued.
- All internal arithmetic is unsigned. cnt never wraps because of the width constraint on CNT_W.

Decomposition:
- Package sc_pkg holds:
  - the state enum (IDLE, INIT, RUN, FIN);
  - the default TAPS constant, 8'hB8, plus known maximal masks for widths 4 to 16;
  - the default SEED.
- Sub-module sc_lfsr (ports CLK, RST_N, LOAD, EN, SEED, Q):
  - parameterised LFSR_S/TAPS;
  - reused by the other stochastic generators in the design.
- Top level contains the FSM, the counter and the comparator.

Test Plan:
- Reset then idle: RST_N low for 3 cycles, then high, with no START.
  - Required: C=0, INIT=0, BUSY=0, DONE=0, CYC_CNT=0, SEL=8'h01, stable for 20 cycles.
- LFSR sequence: START with SEED=1.
  - Required: SEL over the first INIT cycles is 01, B8, 5C, 2E, 17, B3.
  - Required: SEL returns to 01 after 255 advances.
- Frame timing: INIT_CYC=8, RUN_CYC=16, one START pulse.
  - Required: INIT high for exactly 8 cycles, then BUSY high without INIT for 16 cycles.
  - Required: DONE high for 1 cycle; BUSY=0 in that cycle.
- Probability extremes and exactness: RUN_CYC=255, INIT_CYC=0 not allowed, so use INIT_CYC=8.
  - P=0 → 0 ones on C during RUN.
  - P=8'hFF → 255 ones during RUN.
  - P=8'h80 → C ones counted over a 255-cycle window = 128.
- Ignored START and P change: pulse START and change P from 8'h40 to 8'hC0 during RUN.
  - Required: frame length unchanged.
  - Required: C density stays at the P=8'h40 value; no second frame starts.
- Mid-frame reset: assert RST_N=0 at RUN cycle 5.
  - Required: INIT, BUSY and C are 0 within the same cycle; no DONE.
  - Required: after release, the block is in IDLE and SEL=8'h01.
